fc_acc_relu: RTL and testbench



---
 rtl/fc_acc_relu_if.sv | 29 ++
 rtl/fc_acc_relu.sv | 103 ++++++++++
 tb/tb_fc_acc_relu.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fc_acc_relu_if.sv
// ============================================================================
// Module      : fc_acc_relu_if
// Description : Product-in / result-out handshake bundle for fc_acc_relu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fc_acc_relu_if;
   logic [31:0] prod_din;
   logic        prod_valid;
   logic        prod_ready;
   logic [15:0] bias_din;
   logic [15:0] out_dout;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   modport master (
      output prod_din, prod_valid, bias_din, out_ready,
      input  prod_ready, out_dout, out_valid, busy
   );

   modport slave (
      input  prod_din, prod_valid, bias_din, out_ready,
      output prod_ready, out_dout, out_valid, busy
   );
endinterface

`default_nettype wire

// File: rtl/fc_acc_relu.sv
// ============================================================================
// Module      : fc_acc_relu
// Description : FC neuron tail: accumulate NUM_IN products plus bias, round
//               Q16.16 -> Q8.8, optional ReLU, saturate, valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_acc_relu #(
   parameter int NUM_IN    = 64,
   parameter int ACC_WIDTH = 40,
   parameter int FRAC_BITS = 8,
   parameter int RELU_EN   = 1
) (
   input  logic           ap_clk,
   input  logic           ap_rst,
   fc_acc_relu_if.slave   bus
);

   localparam int                         c_cnt_w    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam logic [c_cnt_w-1:0]         c_cnt_last = c_cnt_w'(NUM_IN - 1);
   localparam logic [1:0]                 c_st_acc   = 2'd0;
   localparam logic [1:0]                 c_st_scale = 2'd1;
   localparam logic [1:0]                 c_st_out   = 2'd2;
   localparam logic signed [ACC_WIDTH-1:0] c_round   = ACC_WIDTH'(1) << (FRAC_BITS - 1);
   localparam logic signed [ACC_WIDTH-1:0] c_sat_max = ACC_WIDTH'(32767);
   localparam logic signed [ACC_WIDTH-1:0] c_sat_min = ~c_sat_max;

   logic [1:0]                  r_state;
   logic [c_cnt_w-1:0]          r_cnt;
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic [15:0]                 r_dout;
   logic                        r_valid;

   logic signed [ACC_WIDTH-1:0] w_prod_ext;
   logic signed [ACC_WIDTH-1:0] w_bias_ext;
   logic signed [ACC_WIDTH-1:0] w_sum;
   logic signed [ACC_WIDTH-1:0] w_shr;
   logic [15:0]                 w_sat;
   logic                        w_prod_xfer;

   assign w_prod_ext  = {{(ACC_WIDTH-32){bus.prod_din[31]}}, bus.prod_din};
   assign w_bias_ext  = {{(ACC_WIDTH-16){bus.bias_din[15]}}, bus.bias_din} << FRAC_BITS;
   // First beat of a neuron seeds the sum with the bias instead of the old acc.
   assign w_sum       = ((r_cnt == '0) ? w_bias_ext : r_acc) + w_prod_ext;
   assign w_shr       = (r_acc + c_round) >>> FRAC_BITS;
   assign w_prod_xfer = bus.prod_valid && (r_state == c_st_acc);

   always_comb begin
      w_sat = w_shr[15:0];
      if ((RELU_EN != 0) && w_shr[ACC_WIDTH-1]) begin
         w_sat = 16'h0000;
      end else if (w_shr > c_sat_max) begin
         w_sat = 16'h7fff;
      end else if (w_shr < c_sat_min) begin
         w_sat = 16'h8000;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state <= c_st_acc;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            c_st_acc: begin
               if (w_prod_xfer) begin
                  r_acc <= w_sum;
                  if (r_cnt == c_cnt_last) begin
                     r_cnt   <= '0;
                     r_state <= c_st_scale;
                  end else begin
                     r_cnt <= r_cnt + c_cnt_w'(1);
                  end
               end
            end
            c_st_scale: begin
               r_dout  <= w_sat;
               r_valid <= 1'b1;
               r_state <= c_st_out;
            end
            c_st_out: begin
               if (bus.out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= c_st_acc;
               end
            end
            default: r_state <= c_st_acc;
         endcase
      end
   end

   assign bus.prod_ready = (r_state == c_st_acc);
   assign bus.out_dout   = r_dout;
   assign bus.out_valid  = r_valid;
   assign bus.busy       = (r_cnt != '0) || (r_state != c_st_acc);

endmodule

`default_nettype wire

// File: tb/tb_fc_acc_relu.sv
// ============================================================================
// Module      : tb_fc_acc_relu
// Description : Directed + random bench for fc_acc_relu, ReLU on and off.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_acc_relu;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   first_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fc_acc_relu_if if_r ();
   fc_acc_relu_if if_n ();

   assign if_n.prod_din   = if_r.prod_din;
   assign if_n.prod_valid = if_r.prod_valid;
   assign if_n.bias_din   = if_r.bias_din;
   assign if_n.out_ready  = if_r.out_ready;

   fc_acc_relu #(.NUM_IN(4), .ACC_WIDTH(40), .FRAC_BITS(8), .RELU_EN(1)) dut_r (
      .ap_clk (clk),
      .ap_rst (rst),
      .bus    (if_r.slave)
   );

   fc_acc_relu #(.NUM_IN(4), .ACC_WIDTH(40), .FRAC_BITS(8), .RELU_EN(0)) dut_n (
      .ap_clk (clk),
      .ap_rst (rst),
      .bus    (if_n.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: bias*2^8 + sum of products, round half up, shift, clamp.
   function automatic logic [15:0] model(input logic [31:0] p [4], input logic [15:0] bias,
                                         input bit relu);
      longint s;
      s = longint'($signed(bias)) * 256;
      for (int i = 0; i < 4; i++) s = s + longint'($signed(p[i]));
      s = (s + 128) >>> 8;
      if (relu && s < 0) s = 0;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s[15:0];
   endfunction

   task automatic run_neuron(input string name, input logic [31:0] p [4], input logic [15:0] bias,
                             input bit gaps, input int hold,
                             input logic [15:0] exp_r, input logic [15:0] exp_n);
      for (int i = 0; i < 4; i++) begin
         if (gaps && i > 0) begin
            if_r.prod_valid = 1'b0;
            if_r.prod_din   = $urandom;
            step();
         end
         if_r.prod_din   = p[i];
         if_r.prod_valid = 1'b1;
         if_r.bias_din   = (i == 0) ? bias : 16'($urandom);
         chk($sformatf("%s.ready%0d", name, i), {31'd0, if_r.prod_ready}, 32'd1);
         step();
         if (i == 0) first_cyc = cyc;
         chk($sformatf("%s.busy%0d", name, i), {31'd0, if_n.busy}, 32'd1);
      end
      // Upstream keeps valid high with junk while the block is not ready.
      if_r.prod_din = $urandom;
      chk($sformatf("%s.scale_valid", name), {31'd0, if_r.out_valid}, 32'd0);
      chk($sformatf("%s.scale_ready", name), {31'd0, if_r.prod_ready}, 32'd0);
      step();
      chk($sformatf("%s.valid_r", name), {31'd0, if_r.out_valid}, 32'd1);
      chk($sformatf("%s.valid_n", name), {31'd0, if_n.out_valid}, 32'd1);
      chk($sformatf("%s.dout_r", name), {16'd0, if_r.out_dout}, {16'd0, exp_r});
      chk($sformatf("%s.dout_n", name), {16'd0, if_n.out_dout}, {16'd0, exp_n});
      if (hold > 0) if_r.out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         step();
         chk($sformatf("%s.hold_valid%0d", name, h), {31'd0, if_r.out_valid}, 32'd1);
         chk($sformatf("%s.hold_dout%0d", name, h), {16'd0, if_r.out_dout}, {16'd0, exp_r});
         chk($sformatf("%s.hold_ready%0d", name, h), {31'd0, if_n.prod_ready}, 32'd0);
      end
      if_r.out_ready = 1'b1;
      step();
      if_r.prod_valid = 1'b0;
      chk($sformatf("%s.done_valid", name), {31'd0, if_n.out_valid}, 32'd0);
      chk($sformatf("%s.done_ready", name), {31'd0, if_r.prod_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] p [4];
      logic [15:0] bias;
      int          c0, c1, c2;

      rst             = 1'b1;
      if_r.prod_din   = '0;
      if_r.prod_valid = 1'b0;
      if_r.bias_din   = '0;
      if_r.out_ready  = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      chk("rst.out_valid", {31'd0, if_r.out_valid}, 32'd0);
      chk("rst.busy", {31'd0, if_r.busy}, 32'd0);
      chk("rst.prod_ready", {31'd0, if_n.prod_ready}, 32'd1);
      chk("rst.dout", {16'd0, if_n.out_dout}, 32'd0);

      p = '{32'd65536, 32'd65536, 32'd65536, 32'd65536};
      run_neuron("nominal", p, 16'd256, 1'b0, 0, 16'd1280, 16'd1280);

      p = '{-32'sd65536, -32'sd65536, -32'sd65536, -32'sd65536};
      run_neuron("relu", p, 16'd0, 1'b0, 0, 16'h0000, 16'hFC00);

      p = '{32'd128, 32'd0, 32'd0, 32'd0};
      run_neuron("rnd_up", p, 16'd0, 1'b0, 0, 16'd1, 16'd1);
      p = '{32'd127, 32'd0, 32'd0, 32'd0};
      run_neuron("rnd_dn", p, 16'd0, 1'b0, 0, 16'd0, 16'd0);
      p = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
      run_neuron("sat_pos", p, 16'd0, 1'b0, 0, 16'd32767, 16'd32767);
      p = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
      run_neuron("sat_neg", p, 16'd0, 1'b0, 0, 16'h0000, 16'h8000);

      p = '{32'd65536, 32'd65536, 32'd65536, 32'd65536};
      run_neuron("bp_gaps", p, 16'd512, 1'b1, 5, 16'd1536, 16'd1536);

      run_neuron("b2b0", p, 16'd256, 1'b0, 0, 16'd1280, 16'd1280);
      c0 = first_cyc;
      run_neuron("b2b1", p, -16'sd256, 1'b0, 0, 16'd768, 16'd768);
      c1 = first_cyc;
      run_neuron("b2b2", p, 16'd0, 1'b0, 0, 16'd1024, 16'd1024);
      c2 = first_cyc;
      chk("b2b.period1", 32'(c1 - c0), 32'd6);
      chk("b2b.period2", 32'(c2 - c1), 32'd6);

      for (int i = 0; i < 2; i++) begin
         if_r.prod_din   = 32'd65536;
         if_r.prod_valid = 1'b1;
         if_r.bias_din   = 16'd256;
         step();
      end
      if_r.prod_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst.busy", {31'd0, if_r.busy}, 32'd0);
      chk("midrst.out_valid", {31'd0, if_n.out_valid}, 32'd0);
      chk("midrst.dout", {16'd0, if_r.out_dout}, 32'd0);
      run_neuron("after_rst", p, 16'd0, 1'b0, 0, 16'd1024, 16'd1024);

      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < 4; j++) p[j] = $urandom;
         bias = 16'($urandom);
         run_neuron($sformatf("rand%0d", k), p, bias, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), model(p, bias, 1'b1), model(p, bias, 1'b0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
